// File: rtl/bitonic_sched.sv
`timescale 1ns/1ps
// bitonic_sched: loads N = 2**N_LOG2 elements, sorts them in place with a
// bitonic network that is time-multiplexed onto a single compare-and-swap
// unit (one pair per clock), then streams the sorted buffer out.
//
// Ports
//   CLK, RST_N            clock, asynchronous active-low reset
//   IN_DATA/IN_VALID      element input; IN_READY high only while loading
//   OUT_DATA/OUT_VALID    sorted element output, valid only while draining
//   OUT_READY             downstream accepts OUT_DATA this cycle
//   BUSY                  high while sorting or draining
module bitonic_sched #(
    parameter int DATA_WIDTH = 16,
    parameter int N_LOG2     = 3,
    parameter int POLARITY   = 0,
    parameter int SIGNED     = 0
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic                  BUSY
);
    localparam int N  = 1 << N_LOG2;
    localparam int PW = (N_LOG2 > 1) ? N_LOG2 - 1 : 1;
    localparam int CW = N_LOG2 + 1;
    localparam int KW = 3;  // holds stage index up to 6

    localparam logic [PW-1:0] P_LAST   = PW'(N / 2 - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(N_LOG2);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic          POL_BIT  = (POLARITY != 0);

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

    state_t                 state;
    logic [CW-1:0]          load_cnt, out_cnt;
    logic [KW-1:0]          k, j;
    logic [PW-1:0]          p;
    logic [DATA_WIDTH-1:0]  mem [N];

    // Pair selection: i is p with a zero spliced in at bit j, m is its partner.
    logic [N_LOG2-1:0]      p_ext, lo_mask, idx_i, idx_m;
    logic [N_LOG2:0]        i_sh;
    logic                   desc;
    logic [DATA_WIDTH-1:0]  op_a, op_b;
    logic                   a_gt_b, a_lt_b, swap;

    always_comb begin
        p_ext   = N_LOG2'(p);
        lo_mask = ~({N_LOG2{1'b1}} << j);
        idx_i   = ((p_ext & ~lo_mask) << 1) | (p_ext & lo_mask);
        idx_m   = idx_i | (N_LOG2'(1) << j);
        // Bit k of i picks the direction; at the last stage k == N_LOG2 the
        // bit is always 0, so the whole buffer ends in the base order.
        i_sh    = {1'b0, idx_i} >> k;
        desc    = i_sh[0] ^ POL_BIT;
        op_a    = mem[idx_i];
        op_b    = mem[idx_m];
        if (SIGNED != 0) begin
            a_gt_b = $signed(op_a) > $signed(op_b);
            a_lt_b = $signed(op_a) < $signed(op_b);
        end else begin
            a_gt_b = op_a > op_b;
            a_lt_b = op_a < op_b;
        end
        // Strict compares: equal operands never swap.
        swap    = desc ? a_lt_b : a_gt_b;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= LOAD;
            load_cnt <= '0;
            out_cnt  <= '0;
            k        <= '0;
            j        <= '0;
            p        <= '0;
            for (int e = 0; e < N; e++) mem[e] <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (IN_VALID) begin
                        mem[load_cnt[N_LOG2-1:0]] <= IN_DATA;
                        if (load_cnt == CNT_LAST) begin
                            load_cnt <= '0;
                            state    <= SORT;
                            k        <= KW'(1);
                            j        <= '0;
                            p        <= '0;
                        end else begin
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end
                end
                SORT: begin
                    if (swap) begin
                        mem[idx_i] <= op_b;
                        mem[idx_m] <= op_a;
                    end
                    // p innermost, then j counts down, then k counts up.
                    if (p == P_LAST) begin
                        p <= '0;
                        if (j == '0) begin
                            if (k == K_LAST) begin
                                state <= DRAIN;
                                k     <= '0;
                            end else begin
                                k <= k + 1'b1;
                                j <= k;  // new stage starts at j = (k+1)-1
                            end
                        end else begin
                            j <= j - 1'b1;
                        end
                    end else begin
                        p <= p + 1'b1;
                    end
                end
                DRAIN: begin
                    if (OUT_READY) begin
                        if (out_cnt == CNT_LAST) begin
                            out_cnt <= '0;
                            state   <= LOAD;
                        end else begin
                            out_cnt <= out_cnt + 1'b1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Outputs are pure decodes of registered state, so they hold steady
    // whenever the buffer and out_cnt hold.
    assign IN_READY  = (state == LOAD);
    assign OUT_VALID = (state == DRAIN);
    assign BUSY      = (state != LOAD);
    assign OUT_DATA  = (state == DRAIN) ? mem[out_cnt[N_LOG2-1:0]] : '0;

endmodule

// File: tb/tb_bitonic_sched.sv
`timescale 1ns/1ps
// Bench for bitonic_sched: three instances (ascending unsigned, signed,
// descending) share one stimulus stream and are checked every cycle against
// a phase/sort model built from plain sorting.
module tb_bitonic_sched;
    localparam int DW = 16;
    localparam int NL = 3;
    localparam int N  = 1 << NL;
    localparam int C  = (N / 2) * NL * (NL + 1) / 2;

    typedef logic [N-1:0][DW-1:0] vec_t;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [DW-1:0] IN_DATA = '0;
    logic          IN_VALID = 1'b0;
    logic          OUT_READY = 1'b1;
    logic [2:0]    in_ready, out_valid, busy;
    logic [DW-1:0] out_data [3];

    int total = 0;
    int bad   = 0;
    bit run   = 1'b0;

    always #5 CLK = ~CLK;

    bitonic_sched #(.DATA_WIDTH(DW), .N_LOG2(NL), .POLARITY(0), .SIGNED(0)) u_asc (
        .CLK(CLK), .RST_N(RST_N), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
        .IN_READY(in_ready[0]), .OUT_DATA(out_data[0]), .OUT_VALID(out_valid[0]),
        .OUT_READY(OUT_READY), .BUSY(busy[0]));
    bitonic_sched #(.DATA_WIDTH(DW), .N_LOG2(NL), .POLARITY(0), .SIGNED(1)) u_sgn (
        .CLK(CLK), .RST_N(RST_N), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
        .IN_READY(in_ready[1]), .OUT_DATA(out_data[1]), .OUT_VALID(out_valid[1]),
        .OUT_READY(OUT_READY), .BUSY(busy[1]));
    bitonic_sched #(.DATA_WIDTH(DW), .N_LOG2(NL), .POLARITY(1), .SIGNED(0)) u_dsc (
        .CLK(CLK), .RST_N(RST_N), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
        .IN_READY(in_ready[2]), .OUT_DATA(out_data[2]), .OUT_VALID(out_valid[2]),
        .OUT_READY(OUT_READY), .BUSY(busy[2]));

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h want %0h at %0t", nm, idx, act, exp, $time);
        end
    endtask

    task automatic fail_now(string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    function automatic vec_t with_elem(vec_t v, int i, logic [DW-1:0] d);
        vec_t r = v;
        r[i] = d;
        return r;
    endfunction

    function automatic bit gt(logic [DW-1:0] a, logic [DW-1:0] b, bit sg);
        return sg ? ($signed(a) > $signed(b)) : (a > b);
    endfunction

    // Insertion sort ascending, reversed for descending order.
    function automatic vec_t sort_v(vec_t v, bit sg, bit pol);
        vec_t r = v;
        vec_t o;
        logic [DW-1:0] t;
        for (int a = 1; a < N; a++)
            for (int b = a; b > 0; b--)
                if (gt(r[b-1], r[b], sg)) begin
                    t = r[b-1]; r[b-1] = r[b]; r[b] = t;
                end
        o = r;
        if (pol) for (int a = 0; a < N; a++) o[a] = r[N-1-a];
        return o;
    endfunction

    // Model: phase 0 = loading, 1 = sorting for C cycles, 2 = draining.
    int   ph = 0, lc = 0, sc = 0, oc = 0;
    vec_t ld;
    vec_t srt [3];

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ph <= 0; lc <= 0; sc <= 0; oc <= 0; ld <= '0;
        end else begin
            case (ph)
                0: if (IN_VALID) begin
                    ld <= with_elem(ld, lc, IN_DATA);
                    if (lc == N - 1) begin
                        for (int c = 0; c < 3; c++)
                            srt[c] <= sort_v(with_elem(ld, lc, IN_DATA), c == 1, c == 2);
                        ph <= 1; lc <= 0;
                    end else lc <= lc + 1;
                end
                1: if (sc == C - 1) begin ph <= 2; sc <= 0; end
                   else sc <= sc + 1;
                default: if (OUT_READY) begin
                    if (oc == N - 1) begin ph <= 0; oc <= 0; end
                    else oc <= oc + 1;
                end
            endcase
        end
    end

    always @(negedge CLK) begin
        if (run) begin
            for (int c = 0; c < 3; c++) begin
                chk("in_ready",  c, in_ready[c],  ph == 0);
                chk("out_valid", c, out_valid[c], ph == 2);
                chk("busy",      c, busy[c],      ph != 0);
                chk("out_data",  c, out_data[c],  (ph == 2) ? srt[c][oc] : 16'd0);
            end
        end
    end

    task automatic load_set(vec_t v, bit gaps);
        int tmo;
        for (int e = 0; e < N; e++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                IN_VALID = 1'b0;
                @(posedge CLK); #1;
            end
            IN_VALID = 1'b1;
            IN_DATA  = v[e];
            tmo = 0;
            @(negedge CLK);
            while (!in_ready[0] && tmo < 200) begin
                @(negedge CLK);
                tmo++;
            end
            if (tmo >= 200) fail_now("load_wait");
            @(posedge CLK); #1;
        end
        IN_VALID = 1'b0;
    endtask

    // mode 0: ready held high; 1: random ready with a 3-cycle stall after the
    // 2nd output; 2: junk on IN_VALID/IN_DATA throughout sort and drain.
    task automatic drain_set(int mode);
        int n = 0, hs = 0, hold = 0, tmo = 0;
        OUT_READY = 1'b1;
        while (!out_valid[0] && n < C + 10) begin
            if (mode == 2) begin IN_VALID = 1'b1; IN_DATA = DW'($urandom); end
            @(posedge CLK); #1;
            n++;
        end
        // n edges until OUT_VALID is seen; the first output handshake lands
        // on the next edge.
        chk("first_out_edge", 0, n + 1, C + 1);
        while (hs < N && tmo < 500) begin
            if (mode == 1) begin
                if (hold > 0) begin OUT_READY = 1'b0; hold--; end
                else OUT_READY = 1'($urandom_range(0, 1));
            end
            if (mode == 2) begin IN_VALID = 1'b1; IN_DATA = DW'($urandom); end
            @(negedge CLK);
            if (out_valid[0] && OUT_READY) begin
                hs++;
                if (mode == 1 && hs == 2) hold = 3;
            end
            @(posedge CLK); #1;
            tmo++;
        end
        if (tmo >= 500) fail_now("drain_wait");
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        chk("back_to_load", 0, in_ready[0], 1);
    endtask

    int b_in  [8] = '{'hFFFF, 'h0001, 'h8000, 'h7FFF, 'h0000, 'hFFFE, 'h0002, 'h8001};
    int b_exp [8] = '{'h8000, 'h8001, 'hFFFE, 'hFFFF, 'h0000, 'h0001, 'h0002, 'h7FFF};
    int c_in  [8] = '{3, 3, 1, 9, 0, 9, 5, 1};
    int c_exp [8] = '{9, 9, 5, 3, 3, 1, 1, 0};

    initial begin
        vec_t v;
        repeat (3) @(posedge CLK);
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("rst_in_ready",  c, in_ready[c],  1);
            chk("rst_out_valid", c, out_valid[c], 0);
            chk("rst_out_data",  c, out_data[c],  0);
            chk("rst_busy",      c, busy[c],      0);
        end
        RST_N = 1'b1;
        run   = 1'b1;
        @(posedge CLK); #1;
        chk("post_rst_in_ready", 0, in_ready[0], 1);

        // Reverse-ordered input to ascending output.
        for (int e = 0; e < N; e++) v[e] = DW'(7 - e);
        load_set(v, 1'b0);
        for (int e = 0; e < N; e++) chk("pin_asc", e, srt[0][e], e);
        drain_set(0);

        // Signed ordering.
        for (int e = 0; e < N; e++) v[e] = DW'(b_in[e]);
        load_set(v, 1'b0);
        for (int e = 0; e < N; e++) chk("pin_signed", e, srt[1][e], b_exp[e]);
        drain_set(0);

        // Descending with duplicates.
        for (int e = 0; e < N; e++) v[e] = DW'(c_in[e]);
        load_set(v, 1'b0);
        for (int e = 0; e < N; e++) chk("pin_desc", e, srt[2][e], c_exp[e]);
        drain_set(0);

        // Backpressure during drain.
        for (int e = 0; e < N; e++) v[e] = DW'($urandom);
        load_set(v, 1'b1);
        drain_set(1);

        // Reset in the middle of sorting discards the set.
        for (int e = 0; e < N; e++) v[e] = DW'($urandom);
        load_set(v, 1'b0);
        repeat (10) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #2;
        for (int c = 0; c < 3; c++) begin
            chk("midsort_rst_in_ready",  c, in_ready[c],  1);
            chk("midsort_rst_out_valid", c, out_valid[c], 0);
        end
        @(posedge CLK); #1;
        RST_N = 1'b1;
        for (int e = 0; e < N; e++) v[e] = DW'(e + 1);
        load_set(v, 1'b0);
        for (int e = 0; e < N; e++) chk("pin_after_rst", e, srt[0][e], e + 1);
        drain_set(0);

        // Junk on the input side while busy.
        for (int e = 0; e < N; e++) v[e] = DW'($urandom);
        load_set(v, 1'b0);
        drain_set(2);

        // Random sets, some with narrow value range to force duplicates.
        repeat (8) begin
            for (int e = 0; e < N; e++)
                v[e] = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom);
            load_set(v, 1'b1);
            drain_set(int'($urandom_range(0, 2)));
        end

        repeat (2) @(posedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/bitonic_sched.md
BITONIC_SCHED -- requirements
Module: bitonic_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 16, is the element width in bits.
REQ-002 Parameter N_LOG2, default 3, is log2 of the sort length N (N = 8 at default); legal range 1..6.
REQ-003 Parameter POLARITY, default 0: 0 gives an ascending final order, 1 gives a descending final order.
REQ-004 Parameter SIGNED, default 0: 0 compares unsigned, 1 compares two's-complement.
REQ-005 Port CLK, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 Port RST_N, input, 1 bit, asynchronous active-low reset.
REQ-007 Port IN_DATA, input, DATA_WIDTH bits, the element being loaded.
REQ-008 Port IN_VALID, input, 1 bit, means IN_DATA is valid.
REQ-009 Port IN_READY, output, 1 bit, means the block accepts an element this cycle.
REQ-010 Port OUT_DATA, output, DATA_WIDTH bits, the sorted element.
REQ-011 Port OUT_VALID, output, 1 bit, means OUT_DATA is valid.
REQ-012 Port OUT_READY, input, 1 bit, means the downstream consumes OUT_DATA.
REQ-013 Port BUSY, output, 1 bit, is high in the SORT and DRAIN states.

Function
REQ-014 The block SHALL hold an N-entry buffer and sort it using one shared combinational compare-and-swap unit (one compare per cycle), sequenced by an FSM with states LOAD, SORT and DRAIN.
REQ-015 In LOAD, IN_READY SHALL be 1; each cycle with IN_VALID&IN_READY writes IN_DATA to buf[load_cnt] and increments load_cnt; the Nth handshake moves the FSM to SORT on the next edge.
REQ-016 Outside LOAD, IN_READY SHALL be 0 and IN_VALID SHALL be ignored.
REQ-017 SORT SHALL iterate stage k = 1..N_LOG2 (outer loop), substage j = k-1 down to 0, and pair p = 0..N/2-1 (inner loop), one (k,j,p) per cycle, for C = (N/2)*N_LOG2*(N_LOG2+1)/2 cycles (24 at default).
REQ-018 Pair indices SHALL be i = p with a 0 inserted at bit position j, and m = i | (1<<j).
REQ-019 Pair direction SHALL be ascending when bit k of i is 0 and descending otherwise; when POLARITY=1, every direction is inverted.
REQ-020 In each SORT cycle, buf[i] SHALL receive the min (ascending) or max (descending) of buf[i] and buf[m], and buf[m] SHALL receive the other value; the result is written the same edge.
REQ-021 Equal operands SHALL leave both entries unchanged.
REQ-022 Comparison signedness SHALL follow SIGNED.
REQ-023 After the C-th compare edge, the FSM SHALL enter DRAIN; OUT_VALID SHALL therefore first rise C+1 cycles after the edge that accepted the Nth input (25 at default).
REQ-024 In DRAIN, OUT_VALID SHALL be 1 and OUT_DATA SHALL be buf[out_cnt]; each OUT_VALID&OUT_READY handshake increments out_cnt.
REQ-025 While OUT_READY is 0, OUT_DATA and OUT_VALID SHALL remain stable.
REQ-026 The Nth output handshake SHALL return the FSM to LOAD with both counters at 0; IN_READY SHALL rise on the following cycle, with no direct DRAIN-to-LOAD overlap.
REQ-027 Outside DRAIN, OUT_VALID SHALL be 0 and OUT_DATA SHALL be 0.
REQ-028 Counters SHALL be sized exactly (load_cnt/out_cnt N_LOG2+1 bits, p N_LOG2-1 bits minimum 1); no wrap may occur within an operation.

Reset
REQ-029 RST_N low SHALL asynchronously force state LOAD, load_cnt = out_cnt = k = j = p = 0, and all buffer entries to 0.
REQ-030 While RST_N is low, outputs SHALL be IN_READY=1, OUT_VALID=0, OUT_DATA=0, BUSY=0; IN_READY=1 holds after deassertion.
REQ-031 Reset asserted mid-LOAD, mid-SORT or mid-DRAIN SHALL abort the operation and discard the data; the first post-reset handshake is element 0 of a new set.

Verification
REQ-032 Load 7,6,5,4,3,2,1,0 with OUT_READY=1 -> outputs 0,1,...,7 on consecutive cycles; first OUT_VALID 25 cycles after the last input handshake; BUSY high throughout.
REQ-033 SIGNED=1, load 0xFFFF,0x0001,0x8000,0x7FFF,0x0000,0xFFFE,0x0002,0x8001 -> 0x8000,0x8001,0xFFFE,0xFFFF,0x0000,0x0001,0x0002,0x7FFF.
REQ-034 POLARITY=1, load 3,3,1,9,0,9,5,1 -> 9,9,5,3,3,1,1,0 (duplicates preserved).
REQ-035 During DRAIN, toggle OUT_READY randomly (OUT_READY=0 for 3 cycles after the 2nd output) -> OUT_DATA holds buf[2] stable, no element lost or duplicated; IN_READY stays 0 until after the 8th handshake.
REQ-036 Pulse RST_N low at SORT cycle 10 -> OUT_VALID never rises; IN_READY=1 immediately; a fresh load of 1..8 then yields the correct sorted output.
REQ-037 Drive IN_VALID=1 with junk during SORT and DRAIN -> junk is ignored and the sorted output is unchanged.
